// File: rtl/tpu_pkg.sv
// Shared constants and types for the systolic matmul path.
// DIM/IDX_W size the array; FEED_LEN/DRAIN_LEN size the sequencer phases.
package tpu_pkg;

  localparam int DIM       = 4;
  localparam int IDX_W     = 2;
  localparam int FEED_LEN  = 2*DIM-1;
  localparam int DRAIN_LEN = DIM-1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    READOUT
  } seq_state_t;

endpackage

// File: rtl/skew_gen.sv
// Operand stagger decode: step t -> per-line read enable and element index.
// Ports: active, t in; rd_en (DIM), rd_elem (DIM*IDX_W, line i at [i*IDX_W +: IDX_W]) out.
module skew_gen
  import tpu_pkg::*;
(
  input  logic                 active,
  input  logic [IDX_W:0]       t,
  output logic [DIM-1:0]       rd_en,
  output logic [DIM*IDX_W-1:0] rd_elem
);

  // Line i lags line 0 by i steps; it reads element t-i while in range.
  always_comb begin
    rd_en   = '0;
    rd_elem = '0;
    for (int i = 0; i < DIM; i++) begin
      if (active && int'(t) >= i && int'(t) - i < DIM) begin
        rd_en[i]                 = 1'b1;
        rd_elem[i*IDX_W +: IDX_W] = IDX_W'(int'(t) - i);
      end
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Sequencer for the output-stationary systolic matmul: clear, skewed feed, drain, readout.
// Ports: clk, rst, start, result_ready in; busy, done, array_clr, array_we, rd_en, rd_elem, out_row, out_col, result_valid out.
module matmul_sequencer
  import tpu_pkg::*;
#(
  parameter int RD_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 array_clr,
  output logic                 array_we,
  output logic [DIM-1:0]       rd_en,
  output logic [DIM*IDX_W-1:0] rd_elem,
  output logic [IDX_W-1:0]     out_row,
  output logic [IDX_W-1:0]     out_col,
  output logic                 result_valid,
  input  logic                 result_ready
);

  localparam int TW = IDX_W+1;
  localparam int IW = 2*IDX_W;

  localparam logic [TW-1:0] T_FEED_LAST  = TW'(FEED_LEN-1);
  localparam logic [TW-1:0] T_DRAIN_LAST = TW'(DRAIN_LEN+RD_LAT-1);
  localparam logic [TW-1:0] T_WE_DRAIN   = TW'(DRAIN_LEN);
  localparam logic [IW-1:0] IDX_LAST     = IW'(DIM*DIM-1);

  seq_state_t    state, state_n;
  logic [TW-1:0] t, t_n;
  logic [IW-1:0] idx, idx_n;
  logic          done_q, done_n;
  logic          we_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      t      <= '0;
      idx    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      t      <= t_n;
      idx    <= idx_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    t_n     = t;
    idx_n   = idx;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = CLEAR;
      end
      CLEAR: begin
        state_n = FEED;
        t_n     = '0;
      end
      FEED: begin
        if (t == T_FEED_LAST) begin
          state_n = DRAIN;
          t_n     = '0;
        end else begin
          t_n = t + 1'b1;
        end
      end
      DRAIN: begin
        if (t == T_DRAIN_LAST) begin
          state_n = READOUT;
          t_n     = '0;
          idx_n   = '0;
        end else begin
          t_n = t + 1'b1;
        end
      end
      READOUT: begin
        if (result_ready) begin
          // Index wraps to 0 on the final handshake.
          idx_n = idx + 1'b1;
          if (idx == IDX_LAST) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // MAC enable covers the feed plus the time for the last operands
  // to ripple DIM-1 hops to the far corner PE.
  assign we_req = (state == FEED) ||
                  (state == DRAIN && t < T_WE_DRAIN);

  if (RD_LAT == 1) begin : g_lat1
    logic we_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) we_q <= 1'b0;
      else     we_q <= we_req;
    end
    assign array_we = we_q;
  end else begin : g_lat0
    assign array_we = we_req;
  end

  skew_gen u_skew (
    .active  (state == FEED),
    .t       (t),
    .rd_en   (rd_en),
    .rd_elem (rd_elem)
  );

  assign busy         = (state != IDLE);
  assign done         = done_q;
  assign array_clr    = (state == CLEAR);
  assign result_valid = (state == READOUT);
  assign out_row      = idx[IW-1:IDX_W];
  assign out_col      = idx[IDX_W-1:0];

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer (RD_LAT=0 and RD_LAT=1 instances).
// Includes a behavioural systolic array fed by the RD_LAT=1 instance.
module tb_matmul_sequencer;

  logic clk = 1'b0;
  logic rst, start, ready;

  logic       busy0, done0, clr0, we0, valid0;
  logic [3:0] rd_en0;
  logic [7:0] rd_elem0;
  logic [1:0] row0, col0;

  logic       busy1, done1, clr1, we1, valid1;
  logic [3:0] rd_en1;
  logic [7:0] rd_elem1;
  logic [1:0] row1, col1;

  int n_cmp = 0;
  int n_bad = 0;

  int A [4][4];
  int B [4][4];
  int C [4][4];
  int acc  [4][4];
  int areg [4][4];
  int breg [4][4];
  logic [3:0] rdq_en;
  logic [7:0] rdq_elem;

  always #5 clk = ~clk;

  matmul_sequencer #(.RD_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy0), .done(done0), .array_clr(clr0), .array_we(we0),
    .rd_en(rd_en0), .rd_elem(rd_elem0),
    .out_row(row0), .out_col(col0),
    .result_valid(valid0), .result_ready(ready)
  );

  matmul_sequencer #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy1), .done(done1), .array_clr(clr1), .array_we(we1),
    .rd_en(rd_en1), .rd_elem(rd_elem1),
    .out_row(row1), .out_col(col1),
    .result_valid(valid1), .result_ready(ready)
  );

  // Registered operand memories (1-cycle latency) feeding a 4x4
  // output-stationary array: A flows right, B flows down.
  always @(posedge clk) begin : array_model
    int ain, bin;
    if (rst || clr1) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          acc[r][c]  <= 0;
          areg[r][c] <= 0;
          breg[r][c] <= 0;
        end
    end else if (we1) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (c == 0)
            ain = rdq_en[r] ? A[r][rdq_elem[r*2 +: 2]] : 0;
          else
            ain = areg[r][c-1];
          if (r == 0)
            bin = rdq_en[c] ? B[rdq_elem[c*2 +: 2]][c] : 0;
          else
            bin = breg[r-1][c];
          acc[r][c]  <= acc[r][c] + ain * bin;
          areg[r][c] <= ain;
          breg[r][c] <= bin;
        end
    end
    rdq_en   <= rst ? 4'b0 : rd_en1;
    rdq_elem <= rst ? 8'b0 : rd_elem1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ready = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({busy0, done0, clr0, we0, rd_en0, rd_elem0, row0, col0, valid0} !== 21'b0) begin
      n_bad++;
      $display("FAIL reset_outs0 got %h exp 0",
        {busy0, done0, clr0, we0, rd_en0, rd_elem0, row0, col0, valid0});
    end
    n_cmp++;
    if ({busy1, done1, clr1, we1, rd_en1, rd_elem1, row1, col1, valid1} !== 21'b0) begin
      n_bad++;
      $display("FAIL reset_outs1 got %h exp 0",
        {busy1, done1, clr1, we1, rd_en1, rd_elem1, row1, col1, valid1});
    end
  endtask

  task automatic test_skew();
    int we_cnt = 0;
    int we_first = -1;
    int we_last = -1;
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (clr0 !== 1'b1 || busy0 !== 1'b1) begin
      n_bad++;
      $display("FAIL clear_cycle got clr=%b busy=%b exp 1 1", clr0, busy0);
    end
    for (int c = 1; c <= 11; c++) begin
      if (we0) begin
        we_cnt++;
        if (we_first < 0) we_first = c;
        we_last = c;
      end
      if (c == 2) begin
        n_cmp++;
        if (rd_en0 !== 4'b0001 || rd_elem0 !== 8'h00) begin
          n_bad++;
          $display("FAIL skew_t0 got en=%b el=%h exp 0001 00", rd_en0, rd_elem0);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if (rd_en0 !== 4'b1111 || rd_elem0 !== 8'h1b) begin
          n_bad++;
          $display("FAIL skew_t3 got en=%b el=%h exp 1111 1b", rd_en0, rd_elem0);
        end
      end
      if (c == 8) begin
        n_cmp++;
        if (rd_en0 !== 4'b1000 || rd_elem0 !== 8'hc0) begin
          n_bad++;
          $display("FAIL skew_t6 got en=%b el=%h exp 1000 c0", rd_en0, rd_elem0);
        end
      end
      if (c == 9) begin
        n_cmp++;
        if (rd_en0 !== 4'b0000 || valid0 !== 1'b0) begin
          n_bad++;
          $display("FAIL drain_start got en=%b valid=%b exp 0000 0", rd_en0, valid0);
        end
      end
      tick();
    end
    n_cmp++;
    if (we_cnt !== 10 || we_first !== 2 || we_last !== 11 || we0 !== 1'b0) begin
      n_bad++;
      $display("FAIL we_span got cnt=%0d first=%0d last=%0d we12=%b exp 10 2 11 0",
        we_cnt, we_first, we_last, we0);
    end
    n_cmp++;
    if (valid0 !== 1'b1) begin
      n_bad++;
      $display("FAIL valid_rise got %b exp 1 at cycle 12", valid0);
    end
  endtask

  task automatic test_readout();
    int bad_steps = 0;
    for (int n = 0; n < 16; n++) begin
      if ({row0, col0} !== 4'(n) || valid0 !== 1'b1 || done0 !== 1'b0) begin
        bad_steps++;
        $display("FAIL readout_step%0d got rc=%h v=%b d=%b exp %h 1 0",
          n, {row0, col0}, valid0, done0, 4'(n));
      end
      tick();
    end
    n_cmp++;
    if (bad_steps !== 0) n_bad++;
    n_cmp++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || valid0 !== 1'b0) begin
      n_bad++;
      $display("FAIL done_pulse got d=%b busy=%b v=%b exp 1 0 0", done0, busy0, valid0);
    end
    tick();
    n_cmp++;
    if (done0 !== 1'b0) begin
      n_bad++;
      $display("FAIL done_once got %b exp 0", done0);
    end
  endtask

  task automatic test_backpressure();
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20 && !valid0; k++) tick();
    n_cmp++;
    if (valid0 !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_wait_valid got %b exp 1", valid0);
    end
    for (int k = 0; k < 5; k++) tick();
    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (row0 !== 2'd1 || col0 !== 2'd1 || valid0 !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_hold%0d got r=%0d c=%0d v=%b exp 1 1 1", k, row0, col0, valid0);
      end
      tick();
    end
    ready = 1'b1;
    n_cmp++;
    if (row0 !== 2'd1 || col0 !== 2'd1) begin
      n_bad++;
      $display("FAIL bp_release got r=%0d c=%0d exp 1 1", row0, col0);
    end
    for (int k = 0; k < 10; k++) tick();
    n_cmp++;
    if (done0 !== 1'b0 || valid0 !== 1'b1 || {row0, col0} !== 4'hf) begin
      n_bad++;
      $display("FAIL bp_last got d=%b v=%b rc=%h exp 0 1 f", done0, valid0, {row0, col0});
    end
    tick();
    n_cmp++;
    if (done0 !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_done got %b exp 1", done0);
    end
  endtask

  task automatic test_start_busy();
    int clr_cnt = 0;
    ready = 1'b1;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 27; c++) begin
      start = (c == 4 || c == 27);
      if (clr0) clr_cnt++;
      tick();
    end
    start = 1'b0;
    n_cmp++;
    if (done0 !== 1'b1 || clr_cnt !== 1 || clr0 !== 1'b0) begin
      n_bad++;
      $display("FAIL start_busy got done=%b clrs=%0d clr=%b exp 1 1 0", done0, clr_cnt, clr0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (clr0 !== 1'b1) begin
      n_bad++;
      $display("FAIL start_in_done got clr=%b exp 1", clr0);
    end
    for (int k = 0; k < 40 && !done0; k++) tick();
    n_cmp++;
    if (done0 !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_timeout got done=%b exp 1", done0);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    n_cmp++;
    if (rd_en0 !== 4'b1111 || we0 !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_t3 got en=%b we=%b exp 1111 1", rd_en0, we0);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy0, clr0, we0, rd_en0, rd_elem0, valid0} !== 16'b0) begin
      n_bad++;
      $display("FAIL async_reset got %h exp 0", {busy0, clr0, we0, rd_en0, rd_elem0, valid0});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_after_reset%0d got busy=%b%b exp 00", k, busy0, busy1);
      end
    end
  endtask

  task automatic test_rdlat1();
    int we_cnt = 0;
    int we_first = -1;
    int we_last = -1;
    int bad_res = 0;
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (we1) begin
        we_cnt++;
        if (we_first < 0) we_first = c;
        we_last = c;
      end
      if (c == 12) begin
        n_cmp++;
        if (valid1 !== 1'b0) begin
          n_bad++;
          $display("FAIL lat1_valid_early got %b exp 0 at cycle 12", valid1);
        end
      end
      tick();
    end
    n_cmp++;
    if (we_cnt !== 10 || we_first !== 3 || we_last !== 12 || we1 !== 1'b0) begin
      n_bad++;
      $display("FAIL lat1_we_span got cnt=%0d first=%0d last=%0d we13=%b exp 10 3 12 0",
        we_cnt, we_first, we_last, we1);
    end
    n_cmp++;
    if (valid1 !== 1'b1) begin
      n_bad++;
      $display("FAIL lat1_valid_rise got %b exp 1 at cycle 13", valid1);
    end
    for (int n = 0; n < 16; n++) begin
      if ({row1, col1} !== 4'(n) || acc[row1][col1] !== C[n/4][n%4]) begin
        bad_res++;
        $display("FAIL lat1_result%0d got rc=%h acc=%0d exp %h %0d",
          n, {row1, col1}, acc[row1][col1], 4'(n), C[n/4][n%4]);
      end
      tick();
    end
    n_cmp++;
    if (bad_res !== 0) n_bad++;
    n_cmp++;
    if (done1 !== 1'b1) begin
      n_bad++;
      $display("FAIL lat1_done got %b exp 1", done1);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        A[i][j] = i + 2*j + 1;
        B[i][j] = 3*i - j + 4;
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        C[i][j] = 0;
        for (int k = 0; k < 4; k++) C[i][j] += A[i][k] * B[k][j];
      end
    test_reset();
    test_skew();
    test_readout();
    test_backpressure();
    test_start_busy();
    test_reset_mid();
    test_rdlat1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
